// File: rtl/ara_runtime_monitor.sv
// Vector-runtime and event profiler for Ara: counts cycles and event strobes while vector work
// is in flight, and snapshots every counter into readable buffers whenever Ara settles idle.
module ara_runtime_monitor #(
    parameter int unsigned NrEvents       = 3,
    parameter int unsigned CntWidth       = 64,
    parameter int unsigned IdleHoldCycles = 0,
    parameter bit          Saturate       = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             sw_en_i,
    input  logic                             clear_i,
    input  logic                             vreq_valid_i,
    input  logic                             ara_idle_i,
    input  logic [NrEvents-1:0]              event_i,
    input  logic [$clog2(NrEvents+1)-1:0]    rd_idx_i,
    output logic [CntWidth-1:0]              rd_data_o,
    output logic                             done_o,
    output logic                             running_o,
    output logic [NrEvents:0]                overflow_o
);

    localparam int unsigned IdxWidth  = $clog2(NrEvents + 1);
    localparam int unsigned IdleWidth = (IdleHoldCycles > 0) ? $clog2(IdleHoldCycles + 1) : 1;
    localparam logic [IdxWidth-1:0]  MaxIdx  = IdxWidth'(NrEvents);
    localparam logic [IdleWidth-1:0] HoldVal = IdleWidth'(IdleHoldCycles);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q [NrEvents+1];
    logic [CntWidth-1:0]   cnt_d [NrEvents+1];
    logic [CntWidth-1:0]   buf_q [NrEvents+1];
    logic [CntWidth-1:0]   buf_d [NrEvents+1];
    logic [NrEvents:0]     ovf_q, ovf_d;
    logic                  pending_q, pending_d;
    logic [IdleWidth-1:0]  idle_cnt_q, idle_cnt_d;
    logic                  done_q, done_d;

    logic                  run;
    logic                  quiet;
    logic                  capture;
    logic [NrEvents:0]     inc;

    assign run     = (state_q == RUN);
    assign quiet   = ara_idle_i & ~vreq_valid_i;
    assign capture = pending_q & quiet & (idle_cnt_q >= HoldVal);
    // Slot 0 is the runtime counter; slot k follows event channel k-1.
    assign inc     = {event_i & {NrEvents{run}}, run};

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        ovf_d      = ovf_q;
        pending_d  = pending_q;
        idle_cnt_d = idle_cnt_q;
        done_d     = 1'b0;

        if (clear_i) begin
            state_d    = IDLE;
            ovf_d      = '0;
            pending_d  = 1'b0;
            idle_cnt_d = '0;
            for (int i = 0; i <= NrEvents; i++) begin
                cnt_d[i] = '0;
                buf_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE:    if (vreq_valid_i && sw_en_i) state_d = RUN;
                RUN:     if (!sw_en_i && ara_idle_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            for (int i = 0; i <= NrEvents; i++) begin
                if (inc[i]) begin
                    if (cnt_q[i] == '1) begin
                        ovf_d[i] = 1'b1;
                        cnt_d[i] = Saturate ? cnt_q[i] : '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CntWidth'(1);
                    end
                end
            end

            if (quiet) begin
                if (idle_cnt_q < HoldVal) idle_cnt_d = idle_cnt_q + IdleWidth'(1);
            end else begin
                idle_cnt_d = '0;
            end

            // Snapshots take the pre-increment values; live counters keep accumulating.
            if (vreq_valid_i) begin
                pending_d = 1'b1;
            end else if (capture) begin
                pending_d = 1'b0;
                buf_d     = cnt_q;
                done_d    = 1'b1;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the buffers are plain registers that software reads after reset, so they are reset too.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ovf_q      <= '0;
            pending_q  <= 1'b0;
            idle_cnt_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i <= NrEvents; i++) begin
                cnt_q[i] <= '0;
                buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            pending_q  <= pending_d;
            idle_cnt_q <= idle_cnt_d;
            done_q     <= done_d;
            for (int i = 0; i <= NrEvents; i++) begin
                cnt_q[i] <= cnt_d[i];
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (rd_idx_i <= MaxIdx) rd_data_o = buf_q[rd_idx_i];
    end

    assign done_o     = done_q;
    assign running_o  = run;
    assign overflow_o = ovf_q;

endmodule

// File: doc/ara_runtime_monitor.md
Name: ara_runtime_monitor

Overview:
Parametrised vector-runtime and event-profiling unit for the Ara SoC. It times vector activity from the first dispatched vector instruction until Ara is idle again. It also counts NrEvents scalar-core stall/event strobes during that window, such as D$/I$ miss and scoreboard full. Each counter is snapshotted into a software-readable buffer on every idle point, with a programmable idle-hold filter, overflow tracking and a synchronous clear.

Parameters:
NrEvents, 3, number of event counter channels (>=1)
CntWidth, 64, width of every live and buffered counter
IdleHoldCycles, 0, consecutive quiet cycles required before a snapshot (0 = snapshot on first quiet cycle)
Saturate, 1, 1 = counters saturate at all-ones; 0 = counters wrap

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
sw_en_i  in  1  software counter enable (hw_cnt_en)
clear_i  in  1  synchronous clear of all state
vreq_valid_i  in  1  vector instruction dispatched to Ara this cycle
ara_idle_i  in  1  Ara fully idle
event_i  in  NrEvents  per-channel event strobes
rd_idx_i  in  $clog2(NrEvents+1)  buffer select: 0 = runtime, k = event k-1
rd_data_o  out  CntWidth  selected buffered value
done_o  out  1  one-cycle pulse: buffers updated
running_o  out  1  FSM in RUN
overflow_o  out  NrEvents+1  sticky overflow flags; bit0 = runtime, bit k = event k-1

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. All registers reset to 0, FSM to IDLE.
- Reset values: rd_data_o=0, done_o=0, running_o=0, overflow_o=0.
- FSM IDLE -> RUN when vreq_valid_i & sw_en_i.
- FSM RUN -> IDLE when !sw_en_i & ara_idle_i. Otherwise it stays in RUN, so dropping sw_en_i mid-run keeps counting until Ara is idle.
- running_o equals (state==RUN).
- Live runtime counter increments by 1 every cycle in RUN.
- Live event counter k increments in RUN when event_i[k]=1.
- At all-ones, a counter holds if Saturate=1 or wraps to 0 if Saturate=0. In both cases the matching overflow bit sets and stays set until clear/reset.
- Pending flag sets on any vreq_valid_i, regardless of sw_en_i.
- Idle counter: increments, saturating at IdleHoldCycles, when ara_idle_i & !vreq_valid_i. It resets to 0 otherwise.
- Capture condition (combinational): pending_q & ara_idle_i & !vreq_valid_i & idle_cnt_q >= IdleHoldCycles.
- On a capture edge: every buffer loads its live counter _q value (pre-increment), pending clears, and done_o is 1 in the next cycle only. Live counters are never reset by capture; they accumulate across captures.
- A vreq_valid_i during an idle-hold window resets the idle counter and blocks capture.
- rd_data_o is a combinational mux of buffers with zero latency. An out-of-range rd_idx_i returns 0.
- clear_i is synchronous and has priority over all other events. It zeroes the live counters, buffers, overflow, pending and idle counter, and forces IDLE; done_o=0 the next cycle.
- Asserting reset mid-run aborts everything to reset values.
- Buffers are only written on capture or clear.

Test Plan:
- Basic run, IdleHoldCycles=0, sw_en_i=1:
  - Stimulus: vreq_valid_i in cycle 10 only; ara_idle_i=0 in cycles 11..30 and 1 from 31.
  - Response: capture in cycle 31, done_o=1 in cycle 32, rd_idx_i=0 gives 20, running_o stays 1.
- Idle hold, IdleHoldCycles=4, same stimulus:
  - Response: capture in cycle 35, rd_data_o=24.
  - Variant: an extra vreq_valid_i in cycle 33 restarts the hold; capture is delayed to cycle 38, and 38 is the deadline only if idle stays 1 throughout.
- Events, IdleHoldCycles=0, same window as the basic run:
  - Stimulus: event_i[1] high in cycles 12..16.
  - Response: rd_idx_i=2 gives 5, rd_idx_i=1 gives 0, rd_idx_i=3 gives 0, out-of-range index gives 0.
- Disable mid-run:
  - Stimulus: sw_en_i falls in cycle 20 while ara_idle_i=0 until cycle 40.
  - Response: running_o drops after the cycle-40 edge; runtime buffer equals cycles spent in RUN; subsequent vreq_valid_i with sw_en_i=0 does not restart counting.
- Overflow, CntWidth=8, RUN held for 300 cycles:
  - Saturate=1: runtime buffer = 255, overflow_o[0]=1.
  - Saturate=0: runtime buffer = 44, overflow_o[0]=1.
- Clear and reset:
  - clear_i for one cycle mid-run: all buffers 0, overflow_o=0, running_o=0 next cycle.
  - rst_ni low mid-run: same result, asynchronously.
